// File: rtl/pix_ser_pkg.sv
// Shared encodings and helpers for the pixel serializer.
package pix_ser_pkg;

    typedef enum logic [1:0] {
        PLANAR = 2'd0,
        PACK2  = 2'd1,
        CHAIN8 = 2'd2,
        RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Pixels carried by one input word in the given mode; reserved mode
    // steps through the word at the chained rate.
    function automatic int unsigned ppw(input mode_e m, input int unsigned data_w);
        int unsigned n;
        case (m)
            PLANAR:  n = data_w / 32'd4;
            PACK2:   n = data_w / 32'd2;
            CHAIN8:  n = data_w / 32'd8;
            default: n = data_w / 32'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pix_ser_fifo.sv
// Synchronous FIFO with occupancy count, flush and same-cycle push/pop.
module pix_ser_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    import pix_ser_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CNT_W{1'b0}});

    // Storage, pointers and occupancy; flush discards everything held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pix_serializer_p.sv
// Attribute-path serializer: buffers CRT FIFO words and emits one palette
// index per dot enable in planar, 2-bpp packed or 8-bpp chained mode.
module pix_serializer_p
    import pix_ser_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              t_crt_clk,
    input  logic              h_reset_n,
    input  logic              c_dclk_en,
    input  logic              line_start,
    input  logic [1:0]        mode,
    input  logic [1:0]        pix_rep,
    input  logic [3:0]        plane_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    output logic              underrun
);

    localparam int Q     = DATA_W / 4;
    localparam int IDX_W = $clog2(DATA_W / 2);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    mode_e             mode_r;
    logic [1:0]        rep_r;
    state_e            state_r;
    logic [DATA_W-1:0] shift_r;
    logic [IDX_W-1:0]  pix_idx_r;
    logic [1:0]        rep_cnt_r;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic [DATA_W-1:0] fifo_head_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic [IDX_W-1:0]  last_idx_s;
    logic              last_step_s;
    logic [DATA_W-1:0] shifted_s;
    logic [7:0]        pix_s;

    assign in_ready    = (fifo_count_s != CNT_W'(BUF_DEPTH)) && !line_start;
    assign fifo_push_s = in_valid && in_ready;

    pix_ser_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (t_crt_clk),
        .rst_n (h_reset_n),
        .flush (line_start),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (in_data),
        .rdata (fifo_head_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    // Detect the final repetition of the final pixel and decide when the
    // shift register takes the FIFO head (idle refill or bubble-free chain).
    always_comb begin
        last_idx_s  = IDX_W'(ppw(mode_r, DATA_W) - 32'd1);
        last_step_s = (rep_cnt_r == rep_r) && (pix_idx_r == last_idx_s);
        fifo_pop_s  = 1'b0;
        if (line_start || fifo_empty_s) begin
            fifo_pop_s = 1'b0;
        end else if (state_r == ST_EMPTY) begin
            fifo_pop_s = 1'b1;
        end else begin
            fifo_pop_s = c_dclk_en && last_step_s;
        end
    end

    // Pixel extraction: slide the current pixel to the top of the word.
    always_comb begin
        shifted_s = shift_r;
        pix_s     = 8'h00;
        case (mode_r)
            PLANAR: begin
                shifted_s = shift_r << pix_idx_r;
                pix_s     = {4'h0, plane_en & {shifted_s[4*Q-1], shifted_s[3*Q-1],
                                               shifted_s[2*Q-1], shifted_s[Q-1]}};
            end
            PACK2: begin
                shifted_s = shift_r << {pix_idx_r, 1'b0};
                pix_s     = {6'h00, shifted_s[DATA_W-1 -: 2]};
            end
            CHAIN8: begin
                shifted_s = shift_r << {pix_idx_r, 3'b000};
                pix_s     = shifted_s[DATA_W-1 -: 8];
            end
            default: begin
                shifted_s = shift_r;
                pix_s     = 8'h00;
            end
        endcase
    end

    // Serializer FSM: mode latch, shift/index/repeat counters and outputs.
    always_ff @(posedge t_crt_clk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            mode_r    <= PLANAR;
            rep_r     <= 2'd0;
            state_r   <= ST_EMPTY;
            shift_r   <= {DATA_W{1'b0}};
            pix_idx_r <= {IDX_W{1'b0}};
            rep_cnt_r <= 2'd0;
            pix_valid <= 1'b0;
            pix_data  <= 8'h00;
            underrun  <= 1'b0;
        end else if (line_start) begin
            mode_r    <= mode_e'(mode);
            rep_r     <= pix_rep;
            state_r   <= ST_EMPTY;
            shift_r   <= {DATA_W{1'b0}};
            pix_idx_r <= {IDX_W{1'b0}};
            rep_cnt_r <= 2'd0;
            pix_valid <= 1'b0;
            pix_data  <= 8'h00;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            case (state_r)
                ST_EMPTY: begin
                    if (c_dclk_en) begin
                        pix_valid <= 1'b0;
                        pix_data  <= 8'h00;
                        underrun  <= (mode_r != RSVD);
                    end
                    if (fifo_pop_s) begin
                        shift_r   <= fifo_head_s;
                        pix_idx_r <= {IDX_W{1'b0}};
                        rep_cnt_r <= 2'd0;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (c_dclk_en) begin
                        pix_valid <= (mode_r != RSVD);
                        pix_data  <= pix_s;
                        if (rep_cnt_r != rep_r) begin
                            rep_cnt_r <= rep_cnt_r + 2'd1;
                        end else begin
                            rep_cnt_r <= 2'd0;
                            pix_idx_r <= pix_idx_r + IDX_W'(1);
                        end
                        if (last_step_s) begin
                            pix_idx_r <= {IDX_W{1'b0}};
                            if (fifo_pop_s) begin
                                shift_r <= fifo_head_s;
                            end else begin
                                state_r <= ST_EMPTY;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule
